debouncer_multi: RTL



---
 rtl/debouncer_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 135 +++++++++++++
 rtl/debouncer_multi.sv | 40 ++++
 3 files changed

// File: rtl/debouncer_pkg.sv
// Shared definitions for the multi-channel debouncer: channel FSM encoding
// and counter width helpers.
package debouncer_pkg;

  // Wait states mean the stable counter is running (cnt != 0).
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } ch_state_t;

  // Stable counter only has to reach STABLE_CYCLES-1.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction

  // Hold counter saturates at HOLD_CYCLES, so it must be able to hold that value.
  function automatic int unsigned hold_width(input int unsigned hold_cycles);
    return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: synchroniser, stable-time filter FSM, registered
// edge pulses and a once-per-press long-press pulse.
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2_000_000,
  parameter int unsigned HOLD_CYCLES   = 100_000_000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic noisy,
  output logic debounced,
  output logic p_edge,
  output logic n_edge,
  output logic any_edge,
  output logic long_press
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam int unsigned HW = hold_width(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  ch_state_t              state_q, state_n;
  logic [CW-1:0]          cnt_q, cnt_n;
  logic [HW-1:0]          hcnt_q;
  logic                   rise, fall;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain; frozen while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else if (en) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
    end
  end

  // Filter state, stable counter and registered edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE_LO;
      cnt_q    <= '0;
      p_edge   <= 1'b0;
      n_edge   <= 1'b0;
      any_edge <= 1'b0;
    end else if (en) begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      p_edge   <= rise;
      n_edge   <= fall;
      any_edge <= rise | fall;
    end else begin
      p_edge   <= 1'b0;
      n_edge   <= 1'b0;
      any_edge <= 1'b0;
    end
  end

  // Next-state logic: count while s disagrees, flip on the last count,
  // restart on any bounce back.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rise    = 1'b0;
    fall    = 1'b0;
    case (state_q)
      IDLE_LO, WAIT_HI: begin
        if (s) begin
          if (cnt_q == CNT_MAX) begin
            state_n = IDLE_HI;
            cnt_n   = '0;
            rise    = 1'b1;
          end else begin
            state_n = WAIT_HI;
            cnt_n   = cnt_q + CW'(1);
          end
        end else begin
          state_n = IDLE_LO;
          cnt_n   = '0;
        end
      end
      IDLE_HI, WAIT_LO: begin
        if (!s) begin
          if (cnt_q == CNT_MAX) begin
            state_n = IDLE_LO;
            cnt_n   = '0;
            fall    = 1'b1;
          end else begin
            state_n = WAIT_LO;
            cnt_n   = cnt_q + CW'(1);
          end
        end else begin
          state_n = IDLE_HI;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE_LO;
        cnt_n   = '0;
      end
    endcase
  end

  // Debounced level decoded from the registered state.
  always_comb begin
    debounced = (state_q == IDLE_HI) || (state_q == WAIT_LO);
  end

  // Hold counter saturates so long_press fires exactly once per press.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q     <= '0;
      long_press <= 1'b0;
    end else if (en) begin
      long_press <= 1'b0;
      if (debounced) begin
        if (hcnt_q != HOLD_MAX) begin
          hcnt_q     <= hcnt_q + HW'(1);
          long_press <= (hcnt_q == HOLD_MAX - HW'(1));
        end
      end else begin
        hcnt_q <= '0;
      end
    end else begin
      long_press <= 1'b0;
    end
  end

endmodule

// File: rtl/debouncer_multi.sv
// N-channel debouncer: one independent debounce_channel per input bit.
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = 2_000_000,
  parameter int unsigned HOLD_CYCLES   = 100_000_000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] p_edge,
  output logic [N_CH-1:0] n_edge,
  output logic [N_CH-1:0] any_edge,
  output logic [N_CH-1:0] long_press
);

  // One channel instance per input bit.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .noisy     (noisy[i]),
      .debounced (debounced[i]),
      .p_edge    (p_edge[i]),
      .n_edge    (n_edge[i]),
      .any_edge  (any_edge[i]),
      .long_press(long_press[i])
    );
  end

endmodule
